// File: rtl/rename_free_queue_pkg.sv
// Shared types for the rename free-name queue and the renaming register file.
package rename_free_queue_pkg;

  localparam int unsigned NameWidthDflt = 1;
  localparam int unsigned DepthDflt     = 4;
  localparam int unsigned PtrWidthDflt  = 2;

  typedef logic [NameWidthDflt-1:0] name_t;
  typedef logic [PtrWidthDflt-1:0]  ptr_t;

  typedef enum logic {StEmpty, StActive} fq_state_e;

  function automatic fq_state_e fq_next_state(fq_state_e state, logic push, logic pop,
                                              logic count_is_one);
    fq_state_e next;
    next = state;
    unique case (state)
      StEmpty:  if (push) next = StActive;
      StActive: if (pop && !push && count_is_one) next = StEmpty;
      default:  next = StEmpty;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/rename_fifo_core.sv
// Synchronous FIFO holding allocated physical names oldest-first, with head-data output.
module rename_fifo_core #(
  parameter int unsigned Width    = 1,
  parameter int unsigned Depth    = 4,
  parameter int unsigned PtrWidth = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [Width-1:0]    push_data_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [Width-1:0]    head_data_o,
  output logic [PtrWidth:0]   count_o
);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] head_q, head_d;
  logic [PtrWidth-1:0] tail_q, tail_d;
  logic [PtrWidth:0]   count_q, count_d;
  logic                push_fire, pop_fire;

  assign full_o      = (count_q == (PtrWidth+1)'(Depth));
  assign empty_o     = (count_q == '0);
  assign head_data_o = mem_q[head_q];
  assign count_o     = count_q;

  // Full queue rejects pushes even when a pop fires in the same cycle.
  assign push_fire = push_i && !full_o;
  assign pop_fire  = pop_i && !empty_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_fire) tail_d = tail_q + PtrWidth'(1);
    if (pop_fire)  head_d = head_q + PtrWidth'(1);
    if (push_fire && !pop_fire)      count_d = count_q + (PtrWidth+1)'(1);
    else if (pop_fire && !push_fire) count_d = count_q - (PtrWidth+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_fire) mem_q[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/rename_free_queue.sv
// In-order free-name queue: records allocated names and frees the head at commit once not busy.
module rename_free_queue
  import rename_free_queue_pkg::*;
#(
  parameter int unsigned name_width = NameWidthDflt,
  parameter int unsigned depth      = DepthDflt,
  parameter int unsigned ptr_width  = PtrWidthDflt
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ALLOC_E,
  input  logic [name_width-1:0] ALLOC_NAME,
  output logic                  ALLOC_READY,
  input  logic                  COMMIT_E,
  output logic                  COMMIT_READY,
  output logic [name_width-1:0] HEAD_NAME,
  input  logic                  BUSY_IN,
  output logic [name_width-1:0] NAME_F,
  output logic                  FE,
  output logic [ptr_width:0]    COUNT
);

  logic full, empty, push, pop;
  logic [name_width-1:0] name_f_q;
  logic fe_q;
  fq_state_e state_q;

  rename_fifo_core #(
    .Width    (name_width),
    .Depth    (depth),
    .PtrWidth (ptr_width)
  ) u_core (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .push_i      (push),
    .push_data_i (ALLOC_NAME),
    .pop_i       (pop),
    .full_o      (full),
    .empty_o     (empty),
    .head_data_o (HEAD_NAME),
    .count_o     (COUNT)
  );

  assign ALLOC_READY  = !full;
  assign COMMIT_READY = !empty && !BUSY_IN;
  assign push         = ALLOC_E && ALLOC_READY;
  assign pop          = COMMIT_E && COMMIT_READY;

  assign FE     = fe_q;
  assign NAME_F = name_f_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fe_q     <= 1'b0;
      name_f_q <= '0;
      state_q  <= StEmpty;
    end else begin
      fe_q    <= pop;
      if (pop) name_f_q <= HEAD_NAME;
      state_q <= fq_next_state(state_q, push, pop, COUNT == (ptr_width+1)'(1));
    end
  end

  // Control state must always agree with occupancy.
  a_state_matches_count: assert property (@(posedge CLK) disable iff (!RST_N)
    (state_q == StEmpty) == (COUNT == '0));

endmodule

// File: tb/tb_rename_free_queue.sv
// Directed bench for rename_free_queue; free-port outputs checked by a scoreboard monitor.
module tb_rename_free_queue;

  localparam int unsigned NW = 4;
  localparam int unsigned DP = 4;
  localparam int unsigned PW = 2;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          ALLOC_E, COMMIT_E, BUSY_IN;
  logic [NW-1:0] ALLOC_NAME;
  logic          ALLOC_READY, COMMIT_READY, FE;
  logic [NW-1:0] HEAD_NAME, NAME_F;
  logic [PW:0]   COUNT;

  int passed = 0;
  int total  = 0;
  logic [NW-1:0] exp_q[$];

  rename_free_queue #(
    .name_width (NW),
    .depth      (DP),
    .ptr_width  (PW)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .ALLOC_E      (ALLOC_E),
    .ALLOC_NAME   (ALLOC_NAME),
    .ALLOC_READY  (ALLOC_READY),
    .COMMIT_E     (COMMIT_E),
    .COMMIT_READY (COMMIT_READY),
    .HEAD_NAME    (HEAD_NAME),
    .BUSY_IN      (BUSY_IN),
    .NAME_F       (NAME_F),
    .FE           (FE),
    .COUNT        (COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_name(input int n);
    ALLOC_E    = 1'b1;
    ALLOC_NAME = NW'(n);
    tick();
    ALLOC_E    = 1'b0;
  endtask

  // Monitor: every FE pulse must match the oldest expected free.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && FE === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_fe", 1, 0);
      end else begin
        check("name_f", int'(NAME_F), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; ALLOC_E = 1'b0; COMMIT_E = 1'b0; BUSY_IN = 1'b0; ALLOC_NAME = '0;
    repeat (3) tick();
    check("rst_alloc_ready", int'(ALLOC_READY), 1);
    check("rst_commit_ready", int'(COMMIT_READY), 0);
    check("rst_count", int'(COUNT), 0);
    check("rst_fe", int'(FE), 0);
    RST_N = 1'b1;
    tick();
    check("post_rst_count", int'(COUNT), 0);
    check("post_rst_alloc_ready", int'(ALLOC_READY), 1);

    // Busy gating: head held until BUSY_IN drops.
    BUSY_IN = 1'b1; COMMIT_E = 1'b1;
    push_name(5);
    push_name(2);
    check("busy_count", int'(COUNT), 2);
    check("busy_commit_ready", int'(COMMIT_READY), 0);
    tick();
    check("busy_hold_count", int'(COUNT), 2);
    check("busy_head", int'(HEAD_NAME), 5);
    BUSY_IN = 1'b0;
    #1;
    check("unbusy_commit_ready", int'(COMMIT_READY), 1);
    exp_q.push_back(4'd5);
    tick();
    check("busy_fe1", int'(FE), 1);
    check("busy_head_after", int'(HEAD_NAME), 2);
    exp_q.push_back(4'd2);
    tick();
    COMMIT_E = 1'b0;
    check("busy_fe2", int'(FE), 1);
    tick();
    check("busy_fe_low", int'(FE), 0);
    check("busy_count_end", int'(COUNT), 0);
    check("busy_name_f_hold", int'(NAME_F), 2);

    // Full queue.
    push_name(1); push_name(2); push_name(3); push_name(4);
    check("full_count", int'(COUNT), 4);
    check("full_alloc_ready", int'(ALLOC_READY), 0);
    $display("note: deliberate protocol error, push of 7 while full");
    push_name(7);
    check("full_ignore_count", int'(COUNT), 4);
    check("full_ignore_head", int'(HEAD_NAME), 1);
    COMMIT_E = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(NW'(i));
      tick();
    end
    COMMIT_E = 1'b0;
    tick();
    check("full_drained", int'(COUNT), 0);

    // Simultaneous push and pop at count 2.
    push_name(9); push_name(10);
    ALLOC_E = 1'b1; ALLOC_NAME = 4'd11; COMMIT_E = 1'b1;
    exp_q.push_back(4'd9);
    tick();
    ALLOC_E = 1'b0; COMMIT_E = 1'b0;
    check("simul_count", int'(COUNT), 2);
    check("simul_head", int'(HEAD_NAME), 10);
    COMMIT_E = 1'b1;
    exp_q.push_back(4'd10); tick();
    exp_q.push_back(4'd11); tick();
    COMMIT_E = 1'b0;
    tick();
    check("simul_count_end", int'(COUNT), 0);

    // Wrap-around: overlapped push/pop of names 0..9.
    for (int i = 0; i <= 10; i++) begin
      ALLOC_E    = (i <= 9);
      ALLOC_NAME = NW'(i);
      COMMIT_E   = (i > 0);
      if (i > 0) exp_q.push_back(NW'(i - 1));
      tick();
      if (i == 5) check("wrap_count_mid", int'(COUNT), 1);
    end
    ALLOC_E = 1'b0; COMMIT_E = 1'b0;
    tick();
    check("wrap_count_end", int'(COUNT), 0);

    // Empty no-bypass.
    ALLOC_E = 1'b1; ALLOC_NAME = 4'd6; COMMIT_E = 1'b1;
    tick();
    ALLOC_E = 1'b0;
    check("nobypass_fe", int'(FE), 0);
    check("nobypass_count", int'(COUNT), 1);
    exp_q.push_back(4'd6);
    tick();
    COMMIT_E = 1'b0;
    check("nobypass_fe_next", int'(FE), 1);
    tick();

    // Asynchronous reset with entries pending.
    push_name(1); push_name(2); push_name(3);
    check("arst_pre_count", int'(COUNT), 3);
    COMMIT_E = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    check("arst_count", int'(COUNT), 0);
    check("arst_alloc_ready", int'(ALLOC_READY), 1);
    check("arst_fe", int'(FE), 0);
    check("arst_name_f", int'(NAME_F), 0);
    tick();
    RST_N = 1'b1;
    repeat (3) tick();
    COMMIT_E = 1'b0;
    check("arst_count_after", int'(COUNT), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rename_free_queue.md
Name: rename_free_queue

Overview:
- In-order retirement side of the renaming register file: records each physical name as it is allocated and, at commit, drives the file's free-name port.
- Sits between the decode/rename stage (push) and the commit stage (pop).
- Holds allocated names oldest-first.
- A head entry retires only when the pipeline requests commit and the file reports the head name's data as no longer busy.

Parameters:
- name_width, 1, width of a physical register name.
- depth, 4, number of queue entries; must be a power of two, ≥2.
- ptr_width, 2, log2(depth); pointer width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- ALLOC_E  input  1  push request; a name was allocated this cycle.
- ALLOC_NAME  input  name_width  name being allocated (the file's NAME_OUT).
- ALLOC_READY  output  1  queue can accept a push (not full).
- COMMIT_E  input  1  commit stage requests retirement of the oldest entry.
- COMMIT_READY  output  1  head is retirable: not empty and BUSY_IN==0.
- HEAD_NAME  output  name_width  name at head; drives the file's BUSY_NAME port.
- BUSY_IN  input  1  busy bit of HEAD_NAME, returned by the file.
- NAME_F  output  name_width  registered name to free; to the file's NAME_F.
- FE  output  1  registered free-enable; to the file's FE.
- COUNT  output  ptr_width+1  current occupancy, 0..depth.

Behaviour:
- State:
  - Entry array of depth x name_width.
  - Head and tail pointers of ptr_width bits each; both wrap modulo depth.
  - Occupancy counter of ptr_width+1 bits.
  - Output registers for FE and NAME_F.
- Reset (RST_N low, asynchronous): head=0, tail=0, count=0, FE=0, NAME_F=0. Entry contents are don't-care.
  - Hence ALLOC_READY=1, COMMIT_READY=0, COUNT=0.
  - HEAD_NAME equals entry[0] and is undefined while empty.
  - Reset asserted mid-operation discards all entries; no FE pulse is produced for discarded entries.
- Push fires when ALLOC_E && ALLOC_READY:
  - entry[tail] <= ALLOC_NAME.
  - tail <= tail+1, wrapping from depth-1 to 0.
- Pushes while full are ignored with no state change. The producer must not assert ALLOC_E while ALLOC_READY=0, and the verifier flags this as a protocol error.
- ALLOC_READY = (count != depth). It is independent of a same-cycle pop: no pass-through when full.
- Pop fires when COMMIT_E && COMMIT_READY:
  - head <= head+1 with wrap.
  - FE <= 1 and NAME_F <= entry[head] at the same edge.
- In any cycle without a pop, FE <= 0; NAME_F holds its last value.
- Latency: FE/NAME_F appear exactly one cycle after the accepting edge. FE is high for exactly one cycle per pop, so back-to-back pops give FE high on consecutive cycles.
- COMMIT_READY = (count != 0) && !BUSY_IN. It is combinational from BUSY_IN.
- No bypass when empty: a name pushed in cycle N is first poppable in cycle N+1.
- Simultaneous push and pop (count in 1..depth-1): both fire and count is unchanged.
- When full, only the pop fires.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds depth and never underflows.
- Pointer wrap: after depth pushes and depth pops, head and tail are both 0 again and order is preserved across the wrap.
- Control sequencing is a two-state machine:
  - EMPTY (count==0).
  - ACTIVE (count>0).
  - EMPTY->ACTIVE on a push. ACTIVE->EMPTY on a pop with count==1 and no push.
  - The outputs are derived from count; the machine exists for assertion and coverage.
- FE and NAME_F are the file's free-request inputs; FE is never asserted when the queue was empty at the accepting edge.

Decomposition:
- Shared package: a name_t typedef of width name_width and a ptr_t typedef; these are the same types the renaming file uses.
- The queue storage with its pointers and count is a natural sub-module, rename_fifo_core: a synchronous FIFO with push/pop, full/empty and a head-data output.
- The top level adds the busy gating, the registered free outputs and the state machine.

Test Plan:
- Reset: hold RST_N=0, then release → ALLOC_READY=1, COMMIT_READY=0, COUNT=0, FE=0. Assert RST_N low asynchronously between clock edges with COUNT=3 → COUNT=0 immediately, no FE afterwards.
- Busy gating (depth=4):
  - Push names 5, 2 with BUSY_IN=1 and COMMIT_E=1 held → COMMIT_READY=0, no FE.
  - Drop BUSY_IN → pop; the next cycle shows FE=1, NAME_F=5 and HEAD_NAME=2.
  - Then FE=1, NAME_F=2, then FE=0.
- Full queue:
  - Push 1,2,3,4 → COUNT=4, ALLOC_READY=0.
  - A push of 7 while full is flagged as a protocol error and leaves state unchanged.
  - Pops yield NAME_F sequence 1,2,3,4.
- Simultaneous push/pop at COUNT=2 (entries 9,10):
  - Push 11 with the pop → COUNT stays 2, NAME_F=9.
  - The remaining order is 10,11.
- Wrap-around: run 10 push/pop pairs with names 0..9 and BUSY_IN=0 → NAME_F reproduces 0..9 in order, with pointers wrapping twice.
- Empty no-bypass: at COUNT=0, push 6 with COMMIT_E=1 in the same cycle → no FE next cycle. The pop fires in the following cycle, then FE=1, NAME_F=6.
